// File: rtl/hoplite_tx_arbiter.sv
// hoplite_tx_arbiter: network-injection controller for one Fox/Hoplite node.
// Assembles a CPU packet from field writes into a staging register, then commits it
// into a one-deep pending slot. A round-robin arbiter chooses between that slot and
// an aux full-packet requester, and loads the winner into a registered output held
// under valid/ready backpressure.
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   cpu_field_sel/data/we          staging field write (sel 9..15 ignored)
//   cpu_commit                     snapshot staging into the pending slot
//   cpu_ready, cpu_overflow        pending slot empty / sticky dropped-commit flag
//   aux_pkt, aux_valid, aux_ready  aux requester handshake (aux_ready combinational)
//   pkt_out, pkt_out_valid/ready   router inject port
//   sent_cpu_count, sent_aux_count delivered-packet counters per source
module hoplite_tx_arbiter #(
   parameter int COORD_BITS           = 1,
   parameter int MULTICAST_GROUP_BITS = 1,
   parameter int MATRIX_TYPE_BITS     = 1,
   parameter int MATRIX_COORD_BITS    = 8,
   parameter int MATRIX_ELEMENT_BITS  = 32,
   localparam int PACKET_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                                + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [3:0]             cpu_field_sel,
   input  logic [31:0]            cpu_field_data,
   input  logic                   cpu_field_we,
   input  logic                   cpu_commit,
   output logic                   cpu_ready,
   output logic                   cpu_overflow,
   input  logic [PACKET_BITS-1:0] aux_pkt,
   input  logic                   aux_valid,
   output logic                   aux_ready,
   output logic [PACKET_BITS-1:0] pkt_out,
   output logic                   pkt_out_valid,
   input  logic                   pkt_out_ready,
   output logic [15:0]            sent_cpu_count,
   output logic [15:0]            sent_aux_count
);
   typedef struct packed {
      logic [COORD_BITS-1:0]           x;
      logic [COORD_BITS-1:0]           y;
      logic [MULTICAST_GROUP_BITS-1:0] mcast;
      logic                            done;
      logic                            result;
      logic [MATRIX_TYPE_BITS-1:0]     mtype;
      logic [MATRIX_COORD_BITS-1:0]    mx;
      logic [MATRIX_COORD_BITS-1:0]    my;
      logic [MATRIX_ELEMENT_BITS-1:0]  element;
   } pkt_t;
   typedef enum logic {IDLE, HOLD} state_t;
   state_t state, state_nxt;
   pkt_t   stg, stg_nxt, pend, out_q;
   logic   pend_v, ptr_cpu, src_cpu, free, grant_cpu, grant_aux, commit_ok, deliver;
   // Staging with this cycle's field write applied, so a same-cycle commit sees it.
   always_comb begin
      stg_nxt = stg;
      if (cpu_field_we)
         case (cpu_field_sel)
            4'd0: stg_nxt.x       = cpu_field_data[COORD_BITS-1:0];
            4'd1: stg_nxt.y       = cpu_field_data[COORD_BITS-1:0];
            4'd2: stg_nxt.mcast   = cpu_field_data[MULTICAST_GROUP_BITS-1:0];
            4'd3: stg_nxt.done    = cpu_field_data[0];
            4'd4: stg_nxt.result  = cpu_field_data[0];
            4'd5: stg_nxt.mtype   = cpu_field_data[MATRIX_TYPE_BITS-1:0];
            4'd6: stg_nxt.mx      = cpu_field_data[MATRIX_COORD_BITS-1:0];
            4'd7: stg_nxt.my      = cpu_field_data[MATRIX_COORD_BITS-1:0];
            4'd8: stg_nxt.element = cpu_field_data[MATRIX_ELEMENT_BITS-1:0];
            default: ;
         endcase
   end
   // Arbiter: ptr_cpu breaks ties only when both sources are ready.
   always_comb begin
      free      = (state == IDLE) || pkt_out_ready;
      grant_cpu = free && pend_v && (!aux_valid || ptr_cpu);
      grant_aux = free && aux_valid && (!pend_v || !ptr_cpu);
      state_nxt = (grant_cpu || grant_aux) ? HOLD : (free ? IDLE : state);
   end
   always_ff @(posedge clk)
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   // The slot being drained by a CPU grant this cycle may be refilled by the same commit.
   assign commit_ok      = cpu_commit && (!pend_v || grant_cpu);
   assign deliver        = (state == HOLD) && pkt_out_ready;
   assign cpu_ready      = !pend_v;
   assign aux_ready      = reset_n && grant_aux;
   assign pkt_out        = out_q;
   assign pkt_out_valid  = (state == HOLD);
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stg            <= '0;
         pend           <= '0;
         pend_v         <= 1'b0;
         cpu_overflow   <= 1'b0;
         out_q          <= '0;
         src_cpu        <= 1'b0;
         ptr_cpu        <= 1'b1;
         sent_cpu_count <= '0;
         sent_aux_count <= '0;
      end else begin
         stg    <= stg_nxt;
         pend_v <= commit_ok || (pend_v && !grant_cpu);
         if (commit_ok) pend <= stg_nxt;
         if (cpu_commit && !commit_ok) cpu_overflow <= 1'b1;
         if (grant_cpu || grant_aux) begin
            out_q   <= grant_cpu ? pend : pkt_t'(aux_pkt);
            src_cpu <= grant_cpu;
            ptr_cpu <= grant_aux;
         end
         if (deliver && src_cpu)  sent_cpu_count <= sent_cpu_count + 16'd1;
         if (deliver && !src_cpu) sent_aux_count <= sent_aux_count + 16'd1;
      end
   end
endmodule
